lcd_text_driver: RTL and testbench

- Parametrised HD44780-compatible character-LCD driver that owns a ROWS x COLS frame buffer, written through a byte-addressed write port.
- Refreshes only rows marked dirty.
- Timing is derived from cycle-count parameters, so one block serves 16x1, 16x2, 20x4 and 40x2 panels.
- Sits between game/UI logic, which writes characters, and the 8-bit parallel LCD pins.

---
 rtl/lcd_text_driver_if.sv | 23 ++
 rtl/lcd_text_driver.sv | 259 +++++++++++++++++++++++++
 tb/tb_lcd_text_driver.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_driver_if.sv
// Write-port and status bundle between UI logic (master) and lcd_text_driver (slave).
interface lcd_text_driver_if #(
    parameter int RW_W = 1,
    parameter int CW_W = 4
);
    logic            wr_en;
    logic [RW_W-1:0] wr_row;
    logic [CW_W-1:0] wr_col;
    logic [7:0]      wr_char;
    logic            clr_req;
    logic            init_done;
    logic            busy;

    modport master (
        output wr_en, wr_row, wr_col, wr_char, clr_req,
        input  init_done, busy
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_char, clr_req,
        output init_done, busy
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 character-LCD driver: ROWS x COLS frame buffer, dirty-row refresh over the 8-bit bus.
// Define LCD_CURSOR_EN to add cursor_on/cursor_row/cursor_col and cursor control commands.
module lcd_text_driver #(
    parameter int ROWS       = 2,
    parameter int COLS       = 16,
    parameter int PWRUP_CYC  = 750000,
    parameter int CMD_CYC    = 2000,
    parameter int CLR_CYC    = 100000,
    parameter int E_HIGH_CYC = 25,
    parameter int RW_W       = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1,
    parameter int CW_W       = $clog2(COLS)
) (
    input  logic                clk,
    input  logic                reset_n,
    lcd_text_driver_if.slave    bus,
`ifdef LCD_CURSOR_EN
    input  logic                cursor_on,
    input  logic [RW_W-1:0]     cursor_row,
    input  logic [CW_W-1:0]     cursor_col,
`endif
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic                lcd_e,
    output logic [7:0]          lcd_data
);

    typedef enum logic [2:0] {PWRUP, INIT, IDLE, ADDR, DATA, SETUP, STROBE} state_t;

    state_t          state_r;
    state_t          ret_r;
    logic [31:0]     cnt_r;
    logic [31:0]     slot_r;
    logic [2:0]      init_idx_r;
    logic [RW_W-1:0] row_r;
    logic [RW_W-1:0] last_r;
    logic [CW_W:0]   col_r;
    logic [ROWS-1:0] dirty_r;
    logic [7:0]      fb_r [ROWS][COLS];
    logic            lcd_rs_r;
    logic            lcd_e_r;
    logic [7:0]      lcd_data_r;
    logic            init_done_r;
    logic            busy_r;
    logic            found_s;
    logic [RW_W-1:0] found_row_s;
    logic            wr_ok_s;
    logic            dirty_clr_s;

`ifdef LCD_CURSOR_EN
    logic            cur_on_sent_r;
    logic            cur_resync_r;
    logic            cur_mode_r;
    logic [RW_W-1:0] cur_row_sent_r;
    logic [CW_W-1:0] cur_col_sent_r;
    logic            cur_need_s;

    assign cur_need_s = (cursor_on != cur_on_sent_r) ||
                        (cursor_on && (cur_resync_r || (cursor_row != cur_row_sent_r) ||
                                       (cursor_col != cur_col_sent_r)));
`endif

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    init_cmd = (ROWS == 1) ? 8'h30 : 8'h38;
            3'd1:    init_cmd = 8'h0C;
            3'd2:    init_cmd = 8'h01;
            3'd3:    init_cmd = 8'h06;
            default: init_cmd = 8'h0C;
        endcase
    endfunction

    // Odd rows live at 0x40; rows 2/3 continue the 0x00/0x40 lines after COLS characters.
    function automatic logic [6:0] row_base(input logic [RW_W-1:0] r);
        int ri;
        ri = int'(r);
        row_base = 7'(((ri % 2) * 64) + ((ri / 2) * COLS));
    endfunction

    assign wr_ok_s     = bus.wr_en && (32'(bus.wr_row) < 32'(ROWS)) && (32'(bus.wr_col) < 32'(COLS));
    assign dirty_clr_s = (state_r == IDLE) && found_s;

    assign bus.init_done = init_done_r;
    assign bus.busy      = busy_r;
    assign lcd_rs        = lcd_rs_r;
    assign lcd_rw        = 1'b0;
    assign lcd_e         = lcd_e_r;
    assign lcd_data      = lcd_data_r;

    // Round-robin search for the next dirty row, starting after the last one serviced.
    always_comb begin
        found_s     = 1'b0;
        found_row_s = '0;
        for (int k = 1; k <= ROWS; k++) begin
            if (!found_s && dirty_r[(int'(last_r) + k) % ROWS]) begin
                found_s     = 1'b1;
                found_row_s = RW_W'((int'(last_r) + k) % ROWS);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Frame buffer and dirty bits; clear lands before a same-cycle write, and a write re-marks a row being picked up.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    fb_r[r][c] <= 8'h20;
                end
            end
            dirty_r <= '1;
        end else begin
            if (dirty_clr_s) begin
                dirty_r[found_row_s] <= 1'b0;
            end
            if (bus.clr_req) begin
                for (int r = 0; r < ROWS; r++) begin
                    for (int c = 0; c < COLS; c++) begin
                        fb_r[r][c] <= 8'h20;
                    end
                end
                dirty_r <= '1;
            end
            if (wr_ok_s) begin
                fb_r[bus.wr_row][bus.wr_col] <= bus.wr_char;
                dirty_r[bus.wr_row]          <= 1'b1;
            end
        end
    end

    // Controller: issue states load RS/data, SETUP/STROBE run the E pulse and the slot for every byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= PWRUP;
            ret_r       <= INIT;
            cnt_r       <= 32'd0;
            slot_r      <= 32'(CMD_CYC);
            init_idx_r  <= 3'd0;
            row_r       <= '0;
            last_r      <= RW_W'(ROWS - 1);
            col_r       <= '0;
            lcd_rs_r    <= 1'b0;
            lcd_e_r     <= 1'b0;
            lcd_data_r  <= 8'h00;
            init_done_r <= 1'b0;
            busy_r      <= 1'b1;
`ifdef LCD_CURSOR_EN
            cur_on_sent_r  <= 1'b0;
            cur_resync_r   <= 1'b0;
            cur_mode_r     <= 1'b0;
            cur_row_sent_r <= '0;
            cur_col_sent_r <= '0;
`endif
        end else begin
            case (state_r)
                PWRUP: begin
                    if (cnt_r == 32'(PWRUP_CYC - 1)) begin
                        cnt_r      <= 32'd0;
                        init_idx_r <= 3'd0;
                        state_r    <= INIT;
                    end else begin
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                INIT: begin
                    if (init_idx_r == 3'd4) begin
                        init_done_r <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        lcd_rs_r   <= 1'b0;
                        lcd_data_r <= init_cmd(init_idx_r);
                        slot_r     <= (init_idx_r == 3'd2) ? 32'(CLR_CYC) : 32'(CMD_CYC);
                        init_idx_r <= init_idx_r + 3'd1;
                        ret_r      <= INIT;
                        state_r    <= SETUP;
                    end
                end
                IDLE: begin
                    if (found_s) begin
                        row_r   <= found_row_s;
                        last_r  <= found_row_s;
                        busy_r  <= 1'b1;
                        state_r <= ADDR;
`ifdef LCD_CURSOR_EN
                    end else if (cur_need_s) begin
                        lcd_rs_r      <= 1'b0;
                        lcd_data_r    <= cursor_on ? 8'h0E : 8'h0C;
                        slot_r        <= 32'(CMD_CYC);
                        cur_on_sent_r <= cursor_on;
                        cur_mode_r    <= 1'b1;
                        busy_r        <= 1'b1;
                        ret_r         <= ADDR;
                        state_r       <= SETUP;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ADDR: begin
                    lcd_rs_r <= 1'b0;
                    slot_r   <= 32'(CMD_CYC);
                    col_r    <= '0;
                    state_r  <= SETUP;
`ifdef LCD_CURSOR_EN
                    if (cur_mode_r) begin
                        lcd_data_r     <= {1'b1, row_base(cursor_row) + 7'(cursor_col)};
                        cur_row_sent_r <= cursor_row;
                        cur_col_sent_r <= cursor_col;
                        cur_resync_r   <= 1'b0;
                        cur_mode_r     <= 1'b0;
                        ret_r          <= IDLE;
                    end else begin
                        lcd_data_r <= {1'b1, row_base(row_r)};
                        ret_r      <= DATA;
                    end
`else
                    lcd_data_r <= {1'b1, row_base(row_r)};
                    ret_r      <= DATA;
`endif
                end
                DATA: begin
                    if (32'(col_r) == 32'(COLS)) begin
                        state_r <= IDLE;
`ifdef LCD_CURSOR_EN
                        cur_resync_r <= 1'b1;
`endif
                    end else begin
                        lcd_rs_r   <= 1'b1;
                        lcd_data_r <= fb_r[row_r][col_r[CW_W-1:0]];
                        slot_r     <= 32'(CMD_CYC);
                        col_r      <= col_r + 1'b1;
                        ret_r      <= DATA;
                        state_r    <= SETUP;
                    end
                end
                SETUP: begin
                    lcd_e_r <= 1'b1;
                    cnt_r   <= 32'd0;
                    state_r <= STROBE;
                end
                STROBE: begin
                    // The issue state that follows holds the old byte one more cycle, completing the slot.
                    if (cnt_r == slot_r - 32'd2) begin
                        lcd_e_r <= 1'b0;
                        state_r <= ret_r;
                    end else begin
                        lcd_e_r <= ((cnt_r + 32'd1) < 32'(E_HIGH_CYC));
                        cnt_r   <= cnt_r + 32'd1;
                    end
                end
                default: begin
                    lcd_e_r <= 1'b0;
                    state_r <= PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_text_driver.sv
// Bench for lcd_text_driver: decodes the LCD bus into an emulated panel and compares it with a character model.
`timescale 1ns/1ps
module tb_lcd_text_driver;
    localparam int ROWS = 2, COLS = 16, PWRUP_CYC = 100, CMD_CYC = 20, CLR_CYC = 50, E_HIGH_CYC = 4;
    localparam int COLS2 = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    lcd_text_driver_if #(.RW_W(1), .CW_W(4)) bus ();
    lcd_text_driver_if #(.RW_W(1), .CW_W(4)) bus2 ();
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;
    logic       lcd_rs2, lcd_rw2, lcd_e2;
    logic [7:0] lcd_data2;

    lcd_text_driver #(.ROWS(ROWS), .COLS(COLS), .PWRUP_CYC(PWRUP_CYC), .CMD_CYC(CMD_CYC),
                      .CLR_CYC(CLR_CYC), .E_HIGH_CYC(E_HIGH_CYC)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data));

    // Single-row, 12-column panel: the only way to present out-of-range rows and columns.
    lcd_text_driver #(.ROWS(1), .COLS(COLS2), .PWRUP_CYC(PWRUP_CYC), .CMD_CYC(CMD_CYC),
                      .CLR_CYC(CLR_CYC), .E_HIGH_CYC(E_HIGH_CYC)) dut2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2),
        .lcd_rs(lcd_rs2), .lcd_rw(lcd_rw2), .lcd_e(lcd_e2), .lcd_data(lcd_data2));

    int n_cmp = 0;
    int n_mis = 0;
    logic [8:0]   bus_q[$];
    logic [8:0]   bus2_q[$];
    logic [8:0]   exp_q[$];
    time          rise_q[$];
    int           ew_q[$];
    int           e_run = 0;
    bit           busy2_seen;
    byte unsigned ddram [128];
    int           paddr = 0;
    byte unsigned fb_m [ROWS][COLS];
    time          t_rel;

    // Panel emulation: every E rise latches one command or character.
    always @(posedge lcd_e) begin
        bus_q.push_back({lcd_rs, lcd_data});
        rise_q.push_back($time);
        if (!lcd_rs && lcd_data == 8'h01) begin
            for (int i = 0; i < 128; i++) ddram[i] = 8'h20;
            paddr = 0;
        end else if (!lcd_rs && lcd_data[7]) begin
            paddr = int'(lcd_data[6:0]);
        end else if (lcd_rs) begin
            ddram[paddr] = lcd_data;
            paddr = (paddr + 1) % 128;
        end
    end

    always @(posedge lcd_e2) bus2_q.push_back({lcd_rs2, lcd_data2});

    // E pulse widths in clock cycles, plus a sticky busy flag for the small panel.
    always @(negedge clk) begin
        if (lcd_e) begin
            e_run = e_run + 1;
        end else if (e_run != 0) begin
            ew_q.push_back(e_run);
            e_run = 0;
        end
        if (bus2.busy) busy2_seen = 1'b1;
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) fb_m[r][c] = 8'h20;
    endtask

    task automatic wr_main(input int r, input int c, input byte unsigned ch, input bit clr);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_row = 1'(r); bus.wr_col = 4'(c); bus.wr_char = ch; bus.clr_req = clr;
        @(negedge clk);
        bus.wr_en = 1'b0; bus.clr_req = 1'b0;
        if (clr) model_clear();
        fb_m[r][c] = ch;
    endtask

    task automatic wr_small(input int r, input int c, input byte unsigned ch);
        @(negedge clk);
        bus2.wr_en = 1'b1; bus2.wr_row = 1'(r); bus2.wr_col = 4'(c); bus2.wr_char = ch;
        @(negedge clk);
        bus2.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (3) @(negedge clk);
        while (bus.busy && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, bus.busy, 1'b0);
    endtask

    task automatic wait_bus(input int want);
        int n = 0;
        while (bus_q.size() < want && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_bus", bus_q.size() >= want, 1'b1);
    endtask

    function automatic logic [127:0] model_row(input int r);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[8*c +: 8] = fb_m[r][c];
        return v;
    endfunction

    function automatic logic [127:0] panel_row(input int r);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < COLS; c++) v[8*c +: 8] = ddram[(r % 2) * 64 + (r / 2) * COLS + c];
        return v;
    endfunction

    task automatic push_row(input int r);
        exp_q.push_back({1'b0, 1'b1, 7'((r % 2) * 64 + (r / 2) * COLS)});
        for (int c = 0; c < COLS; c++) exp_q.push_back({1'b1, fb_m[r][c]});
    endtask

    task automatic check_stream(input string tag);
        check_val({tag, "_len"}, bus_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check_val($sformatf("%s_b%0d", tag, i), (i < bus_q.size()) ? bus_q[i] : 9'h1FF, exp_q[i]);
    endtask

    task automatic check_panel(input string tag);
        for (int r = 0; r < ROWS; r++) check_val($sformatf("%s_row%0d", tag, r), panel_row(r), model_row(r));
    endtask

    function automatic int count_byte(input logic [8:0] b);
        int n = 0;
        foreach (bus_q[i]) if (bus_q[i] == b) n++;
        return n;
    endfunction

    task automatic check_init(input string tag);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h38}); exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b0, 8'h06});
        push_row(0);
        push_row(1);
        check_stream(tag);
        check_val({tag, "_pwrup"}, (rise_q.size() > 0) && ((rise_q[0] - t_rel) / 10 >= PWRUP_CYC), 1'b1);
        check_val({tag, "_init_done"}, bus.init_done, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_char = 8'h00; bus.clr_req = 1'b0;
        bus2.wr_en = 1'b0; bus2.wr_row = '0; bus2.wr_col = '0; bus2.wr_char = 8'h00; bus2.clr_req = 1'b0;
        for (int i = 0; i < 128; i++) ddram[i] = 8'h00;
        model_clear();
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 1'b1);
        check_val("rst_init_done", bus.init_done, 1'b0);
        check_val("rst_pins", {lcd_rs, lcd_rw, lcd_e, lcd_data, lcd_rw2}, 12'h000);
        t_rel = $time;
        reset_n = 1'b1;

        // Power-up, init commands, full refresh of both rows.
        wait_idle("t1_idle");
        check_init("t1");
        check_val("t1_e_count", ew_q.size(), 38);
        foreach (ew_q[i]) check_val($sformatf("t1_e_width%0d", i), ew_q[i], E_HIGH_CYC);
        check_val("t1_period_cmd", (rise_q[1] - rise_q[0]) / 10, CMD_CYC + 1);
        check_val("t1_period_clr", (rise_q[3] - rise_q[2]) / 10, CLR_CYC + 1);
        check_val("t1_period_data", (rise_q[6] - rise_q[5]) / 10, CMD_CYC + 1);
        check_panel("t1");

        // Single write: only row 1 goes out.
        bus_q.delete();
        wr_main(1, 3, 8'h41, 1'b0);
        wait_idle("t2_idle");
        exp_q.delete();
        push_row(1);
        check_stream("t2");

        // Write landing mid-transfer forces a second pass of the row.
        bus_q.delete();
        wr_main(1, 0, 8'h42, 1'b0);
        wait_bus(9);
        wr_main(1, 5, 8'h5A, 1'b0);
        wait_idle("t3_idle");
        check_val("t3_len", bus_q.size(), 34);
        check_val("t3_row1_addr", count_byte({1'b0, 8'hC0}), 2);
        check_val("t3_row0_addr", count_byte({1'b0, 8'h80}), 0);
        check_val("t3_z_resent", (bus_q.size() > 23) ? bus_q[23] : 9'h1FF, {1'b1, 8'h5A});
        check_panel("t3");

        // Out-of-range writes on the one-row panel stay silent.
        check_val("t4_first_cmd", bus2_q[0], {1'b0, 8'h30});
        check_val("t4_init_len", bus2_q.size(), 4 + 1 + COLS2);
        check_val("t4_busy_idle", bus2.busy, 1'b0);
        bus2_q.delete();
        busy2_seen = 1'b0;
        wr_small(1, 0, 8'h41);
        wr_small(0, COLS2, 8'h42);
        wr_small(0, 15, 8'h43);
        repeat (40) @(negedge clk);
        check_val("t4_no_traffic", bus2_q.size(), 0);
        check_val("t4_busy_stayed_low", busy2_seen, 1'b0);
        wr_small(0, COLS2 - 1, 8'h51);
        for (int n = 0; n < 2000 && bus2_q.size() < COLS2 + 1; n++) @(negedge clk);
        check_val("t4_edge_len", bus2_q.size(), COLS2 + 1);
        check_val("t4_edge_addr", bus2_q[0], {1'b0, 8'h80});
        check_val("t4_edge_char", (bus2_q.size() > COLS2) ? bus2_q[COLS2] : 9'h1FF, {1'b1, 8'h51});

        // Clear with a simultaneous write.
        bus_q.delete();
        wr_main(0, 0, 8'h58, 1'b1);
        wait_idle("t5_idle");
        check_val("t5_len", bus_q.size(), 34);
        check_val("t5_row0_sent", count_byte({1'b0, 8'h80}), 1);
        check_val("t5_row1_sent", count_byte({1'b0, 8'hC0}), 1);
        check_panel("t5");

        // Random bursts of writes, occasionally with a clear, against the panel model.
        for (int rnd = 0; rnd < 6; rnd++) begin
            int nw;
            nw = $urandom_range(8, 1);
            for (int w = 0; w < nw; w++) begin
                wr_main($urandom_range(1, 0), $urandom_range(15, 0), 8'($urandom_range(126, 33)),
                        $urandom_range(15, 0) == 0);
                repeat ($urandom_range(60, 0)) @(negedge clk);
            end
            wait_idle($sformatf("rnd%0d_idle", rnd));
            check_panel($sformatf("rnd%0d", rnd));
        end

        // Reset during a data strobe.
        bus_q.delete();
        wr_main(0, 1, 8'h59, 1'b0);
        wait_bus(3);
        check_val("t6_e_high", lcd_e, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check_val("t6_e_drop", lcd_e, 1'b0);
        check_val("t6_rst_busy", bus.busy, 1'b1);
        check_val("t6_rst_init_done", bus.init_done, 1'b0);
        check_val("t6_rst_data", lcd_data, 8'h00);
        model_clear();
        repeat (3) @(negedge clk);
        bus_q.delete();
        rise_q.delete();
        t_rel = $time;
        reset_n = 1'b1;
        wait_idle("t6_idle");
        check_init("t6");
        check_panel("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
